grid_arbiter: RTL and testbench
===============================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter N, default 4, grid side length; the grid holds N*N cells.
REQ-002 Parameter NODE_W, default 8, node-id width; all-ones is reserved as the EMPTY code (-1).
REQ-003 Parameter CRD_W, default 8, signed coordinate width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester request strobe; bit0 = placer, bit1 = evaluator.
REQ-007 req_ready  out  2  one-hot grant; the request is accepted in the cycle where valid and ready are both high.
REQ-008 req_op  in  2x2  per-requester opcode: 0 READ, 1 CLAIM, 2 RELEASE, 3 CLEAR_ALL.
REQ-009 req_x, req_y  in  2xCRD_W each  per-requester signed cell coordinates.
REQ-010 req_node  in  2xNODE_W  per-requester node id for CLAIM and RELEASE.
REQ-011 rsp_valid  out  2  per-requester response strobe; at most one bit is high at a time.
REQ-012 rsp_ready  in  2  per-requester response accept.
REQ-013 rsp_status  out  2  0 OK, 1 OCCUPIED, 2 OOB, 3 NOT_OWNER.
REQ-014 rsp_data  out  NODE_W  occupant of the addressed cell, sampled before any write.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP, CLEAR.
REQ-017 Grant in IDLE:
  - a single valid requester wins;
  - when both are valid, the round-robin pointer picks the winner;
  - the pointer moves to the loser after every grant.
REQ-018 req_ready is combinational and high only in IDLE; on acceptance the block latches op, coordinates, node and requester index, then goes to EXEC.
REQ-019 Bounds check: the cell is out of bounds when x<0, x>=N, y<0 or y>=N, using a signed compare. An OOB request causes no grid access and returns OOB.
REQ-020 Cell index = x*N + y, width clog2(N*N).
REQ-021 EXEC, READ: returns OK with the occupant in rsp_data.
REQ-022 EXEC, CLAIM:
  - cell EMPTY: write req_node and return OK;
  - cell occupied: no write, return OCCUPIED;
  - the read and the write are atomic within this cycle.
REQ-023 EXEC, RELEASE:
  - occupant equals req_node: write EMPTY and return OK;
  - cell EMPTY: return OK;
  - any other occupant: return NOT_OWNER.
REQ-024 EXEC, CLEAR_ALL: enter CLEAR, write EMPTY to one cell per cycle from index 0 to N*N-1, then go to RESP with OK.
REQ-025 Acceptance-to-rsp_valid latency:
  - 2 cycles for READ, CLAIM and RELEASE;
  - N*N+2 cycles for CLEAR_ALL.
REQ-026 In RESP, rsp_valid, rsp_status and rsp_data hold stable until rsp_ready; the FSM returns to IDLE in the cycle after rsp_ready.
REQ-027 A request arriving while busy is stalled (req_ready low), never dropped.
REQ-028 A requester may assert rsp_ready early; the response is still held for at least one cycle.

Reset
REQ-029 Asynchronous reset forces:
  - state to IDLE and the round-robin pointer to 0;
  - rsp_valid to 0, rsp_status to 0, rsp_data to EMPTY;
  - every grid cell to EMPTY (flop-based storage).
REQ-030 Reset asserted mid-CLEAR or mid-RESP abandons the operation; no response is issued after deassertion.

Configuration
REQ-031 Macro GRID_ARBITER_STATS_EN.
  - Defined: adds outputs occ_count (clog2(N*N)+1 bits, number of non-EMPTY cells) and conflict_count (16 bits, saturating, incremented on every OCCUPIED response); both reset to 0 and occ_count reads 0 after CLEAR_ALL.
  - Undefined: neither port nor the counters exist; all other behaviour is identical.

Structure
REQ-032 Package grid_pkg holds:
  - the opcode enum and the status enum;
  - the FSM state enum;
  - the EMPTY constant function of NODE_W.
REQ-033 Sub-module grid_rr_arb: two-input round-robin arbiter with pointer update, instanced once.

Verification
REQ-034 Reset, then placer CLAIM (0,0) node 0 -> OK two cycles after acceptance; READ (0,0) -> OK, data 0.
REQ-035 Evaluator CLAIM (0,0) node 5 after REQ-034 -> OCCUPIED, data 0; grid unchanged; conflict_count 1 when the macro is defined.
REQ-036 CLAIM (-1,2) and CLAIM (4,0) with N=4 -> OOB; no cell written.
REQ-037 Both requesters valid for 4 consecutive grants -> grants alternate 0,1,0,1; neither request is dropped.
REQ-038 RELEASE (0,0) node 3 while the occupant is 0 -> NOT_OWNER; RELEASE node 0 -> OK, then READ returns EMPTY.
REQ-039 CLEAR_ALL after 3 claims -> rsp_valid 18 cycles after acceptance; all 16 cells EMPTY; reset asserted at cycle 5 of the clear -> no response, state IDLE.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types for the grid arbiter: opcodes, response status, FSM states,
// and the reserved EMPTY node code.
package grid_pkg;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_CLAIM     = 2'd1,
    OP_RELEASE   = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_OCCUPIED  = 2'd1,
    ST_OOB       = 2'd2,
    ST_NOT_OWNER = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  // All-ones code of the given node-id width marks an unoccupied cell.
  function automatic logic [31:0] empty_code(input int unsigned node_w);
    return (node_w >= 32) ? '1 : ((32'd1 << node_w) - 32'd1);
  endfunction

endpackage

// File: rtl/grid_rr_arb.sv
// Two-input round-robin arbiter; after every grant the pointer moves to the
// requester that did not win.
module grid_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ptr <= 1'b0;
    else if (en && (|req))  ptr <= grant[0];
  end

endmodule

// File: rtl/grid_arbiter.sv
// Two-requester arbiter over an N x N occupancy grid (READ/CLAIM/RELEASE/CLEAR_ALL).
// Optional occupancy and conflict counters under GRID_ARBITER_STATS_EN.
module grid_arbiter
  import grid_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned NODE_W = 8,
  parameter int unsigned CRD_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][1:0]        req_op,
  input  logic [1:0][CRD_W-1:0]  req_x,
  input  logic [1:0][CRD_W-1:0]  req_y,
  input  logic [1:0][NODE_W-1:0] req_node,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [NODE_W-1:0]      rsp_data,
  output logic                   busy
`ifdef GRID_ARBITER_STATS_EN
 ,output logic [$clog2(N*N):0]   occ_count,
  output logic [15:0]            conflict_count
`endif
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [NODE_W-1:0]       EMPTY = NODE_W'(empty_code(NODE_W));
  localparam logic signed [CRD_W-1:0] N_S   = CRD_W'(N);

  state_e                   state, state_nxt;
  logic                     idle, accept;
  logic [1:0]               grant;
  op_e                      lat_op;
  logic signed [CRD_W-1:0]  lat_x, lat_y;
  logic [NODE_W-1:0]        lat_node;
  logic                     lat_who;
  logic [IDX_W-1:0]         clr_idx;
  logic                     clr_last;
  logic [NODE_W-1:0]        grid [CELLS];
  logic                     oob;
  logic [IDX_W-1:0]         cell_idx;
  logic [NODE_W-1:0]        occ;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;
  logic [NODE_W-1:0]        wr_data;
  status_e                  exec_status;

  grid_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (idle),
    .grant (grant)
  );

  assign accept   = idle & (|req_valid);
  assign clr_last = (clr_idx == IDX_W'(CELLS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (lat_op == OP_CLEAR_ALL) ? S_CLEAR : S_RESP;
      S_CLEAR: if (clr_last) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[lat_who]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle      = (state == S_IDLE);
    req_ready = idle ? grant : 2'b00;
    busy      = !idle;
  end

  // Single-cycle read-modify-write of the addressed cell while in EXEC.
  always_comb begin
    oob      = lat_x[CRD_W-1] || (lat_x >= N_S) || lat_y[CRD_W-1] || (lat_y >= N_S);
    cell_idx = IDX_W'(lat_x) * IDX_W'(N) + IDX_W'(lat_y);
    occ      = grid[cell_idx];
    wr_en       = 1'b0;
    wr_idx      = cell_idx;
    wr_data     = EMPTY;
    exec_status = ST_OK;
    if (state == S_CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = clr_idx;
    end else if (state == S_EXEC && lat_op != OP_CLEAR_ALL) begin
      if (oob) begin
        exec_status = ST_OOB;
      end else begin
        case (lat_op)
          OP_CLAIM: begin
            if (occ == EMPTY) begin
              wr_en   = 1'b1;
              wr_data = lat_node;
            end else begin
              exec_status = ST_OCCUPIED;
            end
          end
          OP_RELEASE: begin
            if (occ == lat_node)   wr_en = 1'b1;
            else if (occ != EMPTY) exec_status = ST_NOT_OWNER;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_op     <= OP_READ;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_node   <= '0;
      lat_who    <= 1'b0;
      clr_idx    <= '0;
      rsp_valid  <= 2'b00;
      rsp_status <= 2'b00;
      rsp_data   <= EMPTY;
    end else begin
      if (accept) begin
        lat_who  <= grant[1];
        lat_op   <= op_e'(req_op[grant[1]]);
        lat_x    <= req_x[grant[1]];
        lat_y    <= req_y[grant[1]];
        lat_node <= req_node[grant[1]];
      end
      if (state == S_CLEAR) clr_idx <= clr_last ? '0 : clr_idx + IDX_W'(1);
      if (state == S_EXEC && lat_op != OP_CLEAR_ALL) begin
        rsp_valid  <= lat_who ? 2'b10 : 2'b01;
        rsp_status <= exec_status;
        rsp_data   <= oob ? EMPTY : occ;
      end else if (state == S_CLEAR && clr_last) begin
        rsp_valid  <= lat_who ? 2'b10 : 2'b01;
        rsp_status <= ST_OK;
        rsp_data   <= EMPTY;
      end else if (state == S_RESP && rsp_ready[lat_who]) begin
        rsp_valid  <= 2'b00;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CELLS; i++) grid[i] <= EMPTY;
    end else if (wr_en) begin
      grid[wr_idx] <= wr_data;
    end
  end

`ifdef GRID_ARBITER_STATS_EN
  logic [NODE_W-1:0] wr_old;
  assign wr_old = grid[wr_idx];

  // Occupancy tracks every write's effect on its cell; conflicts saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_count      <= '0;
      conflict_count <= '0;
    end else begin
      if (wr_en) begin
        if (wr_old == EMPTY && wr_data != EMPTY)      occ_count <= occ_count + CNT_W'(1);
        else if (wr_old != EMPTY && wr_data == EMPTY) occ_count <= occ_count - CNT_W'(1);
      end
      if (state == S_EXEC && exec_status == ST_OCCUPIED && conflict_count != 16'hFFFF)
        conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grid_arbiter.sv
// Bench for grid_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the grid.
module tb_grid_arbiter;

  localparam int N      = 4;
  localparam int NODE_W = 8;
  localparam int CRD_W  = 8;
  localparam int EMPTY  = (1 << NODE_W) - 1;
  localparam int OP_RD = 0, OP_CL = 1, OP_RL = 2, OP_CA = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [1:0]             req_valid = '0;
  logic [1:0]             req_ready;
  logic [1:0][1:0]        req_op = '0;
  logic [1:0][CRD_W-1:0]  req_x = '0;
  logic [1:0][CRD_W-1:0]  req_y = '0;
  logic [1:0][NODE_W-1:0] req_node = '0;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready = '0;
  logic [1:0]             rsp_status;
  logic [NODE_W-1:0]      rsp_data;
  logic                   busy;
`ifdef GRID_ARBITER_STATS_EN
  logic [$clog2(N*N):0]   occ_count;
  logic [15:0]            conflict_count;
`endif

  always #5 clk = ~clk;

  grid_arbiter #(.N(N), .NODE_W(NODE_W), .CRD_W(CRD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_node   (req_node),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_data),
    .busy       (busy)
`ifdef GRID_ARBITER_STATS_EN
   ,.occ_count      (occ_count),
    .conflict_count (conflict_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: grid contents, tie-break memory, and the
  // countdown until the in-flight response must appear.
  int m_grid [N][N];
  int m_last, m_who, m_lat, m_st, m_dt, m_conf, m_wait, m_w;
  bit m_accepting, m_resp, m_leave;
  int m_exp_rdy;

  function automatic void model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_grid[i][j] = EMPTY;
    m_last = 1; m_wait = 0; m_resp = 0; m_leave = 0; m_accepting = 0; m_conf = 0;
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) if (m_grid[i][j] != EMPTY) c++;
    return c;
  endfunction

  function automatic void model_exec(input int w);
    int op, x, y, nd, occ;
    op = int'(req_op[w]);
    x  = int'($signed(req_x[w]));
    y  = int'($signed(req_y[w]));
    nd = int'(req_node[w]);
    m_lat = 2; m_st = 0; m_dt = EMPTY;
    if (op == OP_CA) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) m_grid[i][j] = EMPTY;
      m_lat = N * N + 2;
    end else if (x < 0 || x >= N || y < 0 || y >= N) begin
      m_st = 2;
    end else begin
      occ  = m_grid[x][y];
      m_dt = occ;
      if (op == OP_CL) begin
        if (occ == EMPTY) m_grid[x][y] = nd;
        else begin m_st = 1; m_conf++; end
      end else if (op == OP_RL) begin
        if (occ == nd) m_grid[x][y] = EMPTY;
        else if (occ != EMPTY) m_st = 3;
      end
    end
  endfunction

  initial model_reset();

  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      if (m_leave) begin
        m_resp = 0; m_leave = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_resp = 1;
      end
      if (m_accepting) begin
        m_accepting = 0;
        m_wait = m_lat - 1;
      end
      chk("busy", int'(busy), int'(m_wait > 0 || m_resp));
      chk("rsp_valid", int'(rsp_valid), m_resp ? (1 << m_who) : 0);
      if (m_resp) begin
        chk("rsp_status", int'(rsp_status), m_st);
        chk("rsp_data", int'(rsp_data), m_dt);
`ifdef GRID_ARBITER_STATS_EN
        chk("occ_count", int'(occ_count), model_occ());
        chk("conflict_count", int'(conflict_count), m_conf);
`endif
        if (rsp_ready[m_who]) m_leave = 1;
      end
      m_exp_rdy = 0;
      if (!m_resp && m_wait == 0 && req_valid != 2'b00) begin
        m_w = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
        m_exp_rdy = 1 << m_w;
        m_last = m_w; m_who = m_w; m_accepting = 1;
        model_exec(m_w);
      end
      chk("req_ready", int'(req_ready), m_exp_rdy);
    end
  end

  task automatic do_op(input int who, input int op, input int x, input int y, input int nd,
                       output int st, output int dt, output int lat);
    int n;
    @(posedge clk); #1;
    req_op[who]   = 2'(op);
    req_x[who]    = CRD_W'(x);
    req_y[who]    = CRD_W'(y);
    req_node[who] = NODE_W'(nd);
    req_valid[who] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[who] && n < 50);
    chk("accepted", int'(req_ready[who]), 1);
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[who] && lat < 60);
    chk("rsp_arrived", int'(rsp_valid[who]), 1);
    st = int'(rsp_status);
    dt = int'(rsp_data);
  endtask

  initial begin
    int st, dt, lat, n, left0, left1, k, x, y;
    int order[$];
    int exp_order[4];
    logic [1:0] acc;
    exp_order = '{0, 1, 0, 1};
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_data", int'(rsp_data), 255);
    chk("reset_rsp_status", int'(rsp_status), 0);
    chk("reset_req_ready", int'(req_ready), 0);

    do_op(0, OP_CL, 0, 0, 0, st, dt, lat);
    chk("claim00_status", st, 0);
    chk("claim00_latency", lat, 2);
    do_op(0, OP_RD, 0, 0, 0, st, dt, lat);
    chk("read00_status", st, 0);
    chk("read00_data", dt, 0);

    do_op(1, OP_CL, 0, 0, 5, st, dt, lat);
    chk("conflict_status", st, 1);
    chk("conflict_data", dt, 0);
`ifdef GRID_ARBITER_STATS_EN
    chk("conflict_count_one", int'(conflict_count), 1);
`endif
    do_op(1, OP_RD, 0, 0, 0, st, dt, lat);
    chk("after_conflict_data", dt, 0);

    do_op(0, OP_CL, -1, 2, 7, st, dt, lat);
    chk("oob_neg_status", st, 2);
    do_op(0, OP_CL, 4, 0, 7, st, dt, lat);
    chk("oob_high_status", st, 2);
    do_op(0, OP_RD, 3, 2, 0, st, dt, lat);
    chk("oob_alias_32_empty", dt, 255);
    do_op(0, OP_RD, 0, 0, 0, st, dt, lat);
    chk("oob_alias_00_kept", dt, 0);

    do_op(0, OP_RL, 0, 0, 3, st, dt, lat);
    chk("release_wrong_status", st, 3);
    chk("release_wrong_data", dt, 0);
    do_op(0, OP_RL, 0, 0, 0, st, dt, lat);
    chk("release_own_status", st, 0);
    do_op(0, OP_RD, 0, 0, 0, st, dt, lat);
    chk("read_after_release", dt, 255);

    do_op(0, OP_CL, 1, 1, 1, st, dt, lat);
    do_op(1, OP_CL, 2, 3, 2, st, dt, lat);
    do_op(0, OP_CL, 3, 0, 3, st, dt, lat);
`ifdef GRID_ARBITER_STATS_EN
    chk("occ_after_claims", int'(occ_count), 3);
`endif
    do_op(1, OP_CA, 0, 0, 0, st, dt, lat);
    chk("clear_latency", lat, 18);
    chk("clear_status", st, 0);
`ifdef GRID_ARBITER_STATS_EN
    chk("occ_after_clear", int'(occ_count), 0);
`endif
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        do_op(i % 2, OP_RD, i, j, 0, st, dt, lat);
        chk("cleared_cell", dt, 255);
      end

    // Reset in the fifth cycle of a clear must abandon it silently.
    do_op(0, OP_CL, 1, 1, 1, st, dt, lat);
    @(posedge clk); #1;
    req_op[0] = 2'(OP_CA);
    req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
    chk("clear_accepted", int'(req_ready[0]), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_mid_clear", int'(busy), 1);
    #1 reset = 1'b1;
    #1 chk("busy_in_reset", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (25) begin
      @(negedge clk);
      chk("no_rsp_after_reset", int'(rsp_valid), 0);
      chk("idle_after_reset", int'(busy), 0);
    end
    do_op(0, OP_RD, 1, 1, 0, st, dt, lat);
    chk("cell_empty_after_reset", dt, 255);

    // Both requesters contending from a fresh pointer.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req_op = '0; req_x = '0; req_y = '0;
    left0 = 2; left1 = 2; n = 0;
    req_valid = 2'b11;
    while ((left0 > 0 || left1 > 0) && n < 200) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc[0]) order.push_back(0);
      if (acc[1]) order.push_back(1);
      @(posedge clk); #1;
      if (acc[0]) begin left0--; if (left0 == 0) req_valid[0] = 1'b0; end
      if (acc[1]) begin left1--; if (left1 == 0) req_valid[1] = 1'b0; end
      n++;
    end
    chk("pair_left0", left0, 0);
    chk("pair_left1", left1, 0);
    chk("pair_grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("pair_grant_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    repeat (4) @(negedge clk);

    // Randomized traffic, both requesters, random response back-pressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          k = int'($urandom_range(0, 19));
          x = int'($urandom_range(0, 5)) - 1;
          y = int'($urandom_range(0, 5)) - 1;
          req_op[r]   = 2'((k == 0) ? OP_CA : k % 3);
          req_x[r]    = CRD_W'(x);
          req_y[r]    = CRD_W'(y);
          req_node[r] = NODE_W'($urandom_range(0, 3));
          req_valid[r] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (40) @(negedge clk);
    chk("drained_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
